// File: rtl/uart_pkg.sv
// Shared definitions for the UART: register offsets, CONF bit positions,
// AXI response codes and the state encoding used by both serial engines.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  // Register offsets (byte addresses on the 3-bit AXI address)
  localparam logic [2:0] REG_DATA = 3'h0;
  localparam logic [2:0] REG_CONF = 3'h4;

  // CONF bit indices
  localparam int unsigned CONF_RX_INT_EN = 0;
  localparam int unsigned CONF_TX_INT_EN = 1;
  localparam int unsigned CONF_RX_FULL   = 2;
  localparam int unsigned CONF_RX_EMPTY  = 3;
  localparam int unsigned CONF_TX_FULL   = 4;
  localparam int unsigned CONF_TX_EMPTY  = 5;
  localparam int unsigned CONF_RX_ERR    = 31;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Serial engine states (shared by TX and RX)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with registered full/empty flags.
// Ports: clk, i_rst (sync, active-high), i_push/i_data write side,
//        i_pop/o_rd_data_c read side (head of queue, combinational),
//        o_full/o_empty occupancy flags.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_rd_data_c,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic              w_do_push;
  logic              w_do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds alongside it
  assign w_do_pop  = i_pop & ~r_empty;
  assign w_do_push = i_push & (~r_full | w_do_pop);

  assign o_rd_data_c = r_mem[r_rd_ptr];
  assign o_full      = r_full;
  assign o_empty     = r_empty;

  // Pointer increment wrapping modulo DEPTH (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push & ~w_do_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (w_do_pop & ~w_do_push) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart.sv
// UART with AXI4-Lite register interface, 8N1 framing and TX/RX FIFOs.
// Ports: clk, rst (sync, active-high); rx/tx serial lines; rx_int/tx_int
//        interrupt requests; AXI4-Lite slave (aw/w/b/ar/r channels) exposing
//        DATA (0x0) and CONF (0x4).
module uart
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BUS_CLK    = 8_000_000,
  parameter int unsigned BAUD       = 1_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic               tx,
  output logic               rx_int,
  output logic               tx_int,
  input  logic               awvalid,
  output logic               awready,
  input  logic [2:0]         awaddr,
  input  logic [2:0]         awprot,
  input  logic               wvalid,
  output logic               wready,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  output logic               bvalid,
  input  logic               bready,
  output logic [1:0]         bresp,
  input  logic               arvalid,
  output logic               arready,
  input  logic [2:0]         araddr,
  input  logic [2:0]         arprot,
  output logic               rvalid,
  input  logic               rready,
  output logic [WIDTH-1:0]   rdata,
  output logic [1:0]         rresp
);

  localparam int unsigned DIV     = BUS_CLK / BAUD;
  localparam int unsigned CNT_W   = $clog2(DIV + 1);
  localparam int unsigned HALF_M1 = (DIV / 2 > 0) ? DIV / 2 - 1 : 0;

  // ---------------- FIFOs ----------------
  logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [BYTE_W-1:0] w_tx_dout, w_rx_dout;
  logic [BYTE_W-1:0] r_rx_shift;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .i_rst(rst), .i_push(w_tx_push), .i_data(wdata[BYTE_W-1:0]),
    .i_pop(w_tx_pop), .o_rd_data_c(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .i_rst(rst), .i_push(w_rx_push), .i_data(r_rx_shift),
    .i_pop(w_rx_pop), .o_rd_data_c(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // ---------------- Register interface ----------------
  logic             r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]       r_bresp, r_rresp;
  logic [WIDTH-1:0] r_rdata, w_conf;
  logic             r_rx_int_en, r_tx_int_en, r_rx_err, w_rx_err_set;
  logic             r_rx_int, r_tx_int, r_tx;
  logic             w_wr_fire, w_rd_fire, w_unused;

  assign w_wr_fire = r_awready & awvalid & wvalid;
  assign w_rd_fire = arvalid & r_arready;
  assign w_tx_push = w_wr_fire & (awaddr == REG_DATA) & (~w_tx_full | w_tx_pop);
  assign w_rx_pop  = w_rd_fire & (araddr == REG_DATA);
  assign w_unused  = ^{awprot, arprot, wstrb, wdata};

  always_comb begin
    w_conf                 = '0;
    w_conf[CONF_RX_INT_EN] = r_rx_int_en;
    w_conf[CONF_TX_INT_EN] = r_tx_int_en;
    w_conf[CONF_RX_FULL]   = w_rx_full;
    w_conf[CONF_RX_EMPTY]  = w_rx_empty;
    w_conf[CONF_TX_FULL]   = w_tx_full;
    w_conf[CONF_TX_EMPTY]  = w_tx_empty;
    w_conf[CONF_RX_ERR]    = r_rx_err;
  end

  // Write channel: single-cycle aw/w acceptance, response held until bready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_awready   <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rx_int_en <= 1'b0;
      r_tx_int_en <= 1'b0;
    end else begin
      r_awready <= awvalid & wvalid & ~r_bvalid & ~r_awready;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        case (awaddr)
          REG_DATA: r_bresp <= w_tx_push ? RESP_OKAY : RESP_SLVERR;
          REG_CONF: begin
            r_bresp     <= RESP_OKAY;
            r_rx_int_en <= wdata[CONF_RX_INT_EN];
            r_tx_int_en <= wdata[CONF_TX_INT_EN];
          end
          default:  r_bresp <= RESP_SLVERR;
        endcase
      end else if (r_bvalid & bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Sticky receive error; a new error in the clearing cycle wins
  always_ff @(posedge clk) begin
    if (rst)                                                  r_rx_err <= 1'b0;
    else if (w_rx_err_set)                                    r_rx_err <= 1'b1;
    else if (w_wr_fire & (awaddr == REG_CONF) & wdata[CONF_RX_ERR]) r_rx_err <= 1'b0;
  end

  // Read channel: arready drops while a response is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (w_rd_fire) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b1;
      case (araddr)
        REG_DATA: begin
          r_rdata <= w_rx_empty ? '0 : WIDTH'(w_rx_dout);
          r_rresp <= w_rx_empty ? RESP_SLVERR : RESP_OKAY;
        end
        REG_CONF: begin
          r_rdata <= w_conf;
          r_rresp <= RESP_OKAY;
        end
        default: begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      endcase
    end else if (r_rvalid & rready) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end else if (~r_rvalid) begin
      r_arready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_int <= 1'b0;
      r_tx_int <= 1'b0;
    end else begin
      r_rx_int <= r_rx_int_en & ~w_rx_empty;
      r_tx_int <= r_tx_int_en & w_tx_empty;
    end
  end

  assign awready = r_awready;
  assign wready  = r_awready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rx_int  = r_rx_int;
  assign tx_int  = r_tx_int;
  assign tx      = r_tx;

  // ---------------- Transmitter ----------------
  uart_state_e       r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0]  r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]        r_tx_bit, w_tx_bit_nxt;
  logic [BYTE_W-1:0] r_tx_shift, w_tx_shift_nxt;
  logic              w_tx_nxt, w_tx_bit_done;

  assign w_tx_bit_done = (r_tx_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // A new frame may start straight out of the stop bit to keep frames back-to-back
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_nxt       = r_tx;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_nxt     = 1'b1;
        if (~w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_dout;
          w_tx_state_nxt = START;
          w_tx_nxt       = 1'b0;
        end
      end
      START: if (w_tx_bit_done) begin
        w_tx_cnt_nxt   = '0;
        w_tx_bit_nxt   = '0;
        w_tx_state_nxt = DATA;
        w_tx_nxt       = r_tx_shift[0];
      end
      DATA: if (w_tx_bit_done) begin
        w_tx_cnt_nxt = '0;
        if (r_tx_bit == 3'd7) begin
          w_tx_state_nxt = STOP;
          w_tx_nxt       = 1'b1;
        end else begin
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          w_tx_shift_nxt = r_tx_shift >> 1;
          w_tx_nxt       = r_tx_shift[1];
        end
      end
      STOP: if (w_tx_bit_done) begin
        w_tx_cnt_nxt = '0;
        if (~w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_dout;
          w_tx_state_nxt = START;
          w_tx_nxt       = 1'b0;
        end else begin
          w_tx_state_nxt = IDLE;
        end
      end
      default: w_tx_state_nxt = IDLE;
    endcase
  end

  // ---------------- Receiver ----------------
  uart_state_e       r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0]  r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]        r_rx_bit, w_rx_bit_nxt;
  logic [BYTE_W-1:0] w_rx_shift_nxt;
  logic              r_rx_meta, r_rx_sync, r_rx_prev;
  logic              w_rx_frame_err, w_rx_bit_done;

  assign w_rx_bit_done = (r_rx_cnt == CNT_W'(DIV - 1));
  // Overflow only when no read frees a slot in the same cycle
  assign w_rx_err_set  = w_rx_frame_err | (w_rx_push & w_rx_full & ~w_rx_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // Start is confirmed half a bit after the edge; later samples land at bit centres
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    w_rx_frame_err = 1'b0;
    case (r_rx_state)
      IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev & ~r_rx_sync) w_rx_state_nxt = START;
      end
      START: if (r_rx_cnt == CNT_W'(HALF_M1)) begin
        w_rx_cnt_nxt   = '0;
        w_rx_bit_nxt   = '0;
        w_rx_state_nxt = r_rx_sync ? IDLE : DATA;
      end
      DATA: if (w_rx_bit_done) begin
        w_rx_cnt_nxt   = '0;
        w_rx_shift_nxt = {r_rx_sync, r_rx_shift[BYTE_W-1:1]};
        w_rx_bit_nxt   = r_rx_bit + 3'd1;
        if (r_rx_bit == 3'd7) w_rx_state_nxt = STOP;
      end
      STOP: if (w_rx_bit_done) begin
        w_rx_cnt_nxt   = '0;
        w_rx_state_nxt = IDLE;
        w_rx_push      = r_rx_sync;
        w_rx_frame_err = ~r_rx_sync;
      end
      default: w_rx_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart.sv
`timescale 1ns/1ps
module tb_uart;
  import uart_pkg::*;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        tx, rx_int, tx_int;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [2:0]  awaddr = '0, araddr = '0, awprot = '0, arprot = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic tx_log [0:1023];

  uart #(.WIDTH(32), .BUS_CLK(8_000_000), .BAUD(1_000_000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .rx_int(rx_int), .tx_int(tx_int),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic axi_write(input logic [2:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int cnt = 0;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && cnt < 20) begin tick(1); cnt++; end
    if (!awready) begin
      n_tests++; n_fail++;
      $display("FAIL aw_timeout: awready never rose, addr %h", addr);
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
      return;
    end
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    cnt = 0;
    while (!bvalid && cnt < 20) begin tick(1); cnt++; end
    if (!bvalid) begin
      n_tests++; n_fail++;
      $display("FAIL b_timeout: bvalid never rose, addr %h", addr);
      resp = 2'b11;
      return;
    end
    resp = bresp; bready = 1'b1;
    tick(1);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [2:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cnt = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && cnt < 20) begin tick(1); cnt++; end
    if (!arready) begin
      n_tests++; n_fail++;
      $display("FAIL ar_timeout: arready never rose, addr %h", addr);
      arvalid = 1'b0; data = 'x; resp = 2'b11;
      return;
    end
    tick(1);
    arvalid = 1'b0;
    cnt = 0;
    while (!rvalid && cnt < 20) begin tick(1); cnt++; end
    if (!rvalid) begin
      n_tests++; n_fail++;
      $display("FAIL r_timeout: rvalid never rose, addr %h", addr);
      data = 'x; resp = 2'b11;
      return;
    end
    data = rdata; resp = rresp; rready = 1'b1;
    tick(1);
    rready = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0; tick(DIV);
    for (int k = 0; k < 8; k++) begin rx = b[k]; tick(DIV); end
    rx = stop; tick(DIV);
    rx = 1'b1; tick(DIV);
  endtask

  task automatic record_tx(input int n);
    for (int i = 0; i < n; i++) begin tick(1); tx_log[i] = tx; end
  endtask

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r;
    rst = 1'b1; tick(2);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b expected 1", tx); end
    n_tests++; if ({rx_int, tx_int} !== 2'b00) begin n_fail++; $display("FAIL rst_int: got %b expected 00", {rx_int, tx_int}); end
    n_tests++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL rst_handshake: got %b expected 00000", {awready, wready, bvalid, arready, rvalid}); end
    n_tests++; if ({bresp, rresp, rdata} !== 36'h0) begin
      n_fail++; $display("FAIL rst_resp_data: got %h expected 0", {bresp, rresp, rdata}); end
    rst = 1'b0; tick(1);
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h0000_0028) begin n_fail++; $display("FAIL conf_after_reset: got %h expected 00000028", d); end
    n_tests++; if (r !== RESP_OKAY) begin n_fail++; $display("FAIL conf_after_reset_resp: got %b expected 00", r); end
  endtask

  task automatic test_tx;
    logic [1:0] r; logic [31:0] d;
    logic [7:0] b = 8'hA5;
    int s = -1; int errs = 0; logic exp;
    fork
      axi_write(REG_DATA, 32'h0000_00A5, r);
      record_tx(120);
    join
    n_tests++; if (r !== RESP_OKAY) begin n_fail++; $display("FAIL tx_write_resp: got %b expected 00", r); end
    for (int i = 0; i < 120; i++) if (s < 0 && tx_log[i] === 1'b0) s = i;
    n_tests++;
    if (s < 1 || s + 88 > 120) begin
      n_fail++; $display("FAIL tx_start: start index %0d outside window", s);
    end else begin
      for (int j = 0; j < 88; j++) begin
        if (j < 8) exp = 1'b0;
        else if (j < 72) exp = b[(j - 8) / 8];
        else exp = 1'b1;
        if (tx_log[s + j] !== exp) errs++;
      end
      if (errs != 0) begin n_fail++; $display("FAIL tx_wave: got %0d wrong samples expected 0", errs); end
    end
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h0000_0028) begin n_fail++; $display("FAIL tx_empty_after: got %h expected 00000028", d); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] r; logic [31:0] d;
    logic [7:0] got [0:7];
    logic [7:0] bt;
    int n = 0; int i = 0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          axi_write(REG_DATA, 32'(8'h11 * (k + 1)), r);
          n_tests++; if (r !== RESP_OKAY) begin n_fail++; $display("FAIL b2b_write%0d: got %b expected 00", k, r); end
        end
        axi_read(REG_CONF, d, r);
        n_tests++; if (d[4] !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_full: got %b expected 1", d[4]); end
        axi_write(REG_DATA, 32'h66, r);
        n_tests++; if (r !== RESP_SLVERR) begin n_fail++; $display("FAIL b2b_overflow_resp: got %b expected 10", r); end
      end
      record_tx(600);
    join
    while (i < 600 - 80 && n < 8) begin
      if (tx_log[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) bt[k] = tx_log[i + 8 * (k + 1) + 4];
        got[n] = bt; n++; i += 80;
      end else i++;
    end
    n_tests++; if (n != 5) begin n_fail++; $display("FAIL b2b_frame_count: got %0d expected 5", n); end
    for (int k = 0; k < 5 && k < n; k++) begin
      n_tests++;
      if (got[k] !== 8'(8'h11 * (k + 1))) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", k, got[k], 8'(8'h11 * (k + 1))); end
    end
  endtask

  task automatic test_rx;
    logic [1:0] r; logic [31:0] d;
    send_rx(8'h3C, 1'b1); tick(4);
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h0000_0020) begin n_fail++; $display("FAIL rx_conf_pending: got %h expected 00000020", d); end
    axi_read(REG_DATA, d, r);
    n_tests++; if (d !== 32'h0000_003C) begin n_fail++; $display("FAIL rx_data: got %h expected 0000003c", d); end
    n_tests++; if (r !== RESP_OKAY) begin n_fail++; $display("FAIL rx_data_resp: got %b expected 00", r); end
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h0000_0028) begin n_fail++; $display("FAIL rx_conf_drained: got %h expected 00000028", d); end
  endtask

  task automatic test_glitch;
    logic [1:0] r; logic [31:0] d;
    rx = 1'b0; tick(2); rx = 1'b1; tick(100);
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h0000_0028) begin n_fail++; $display("FAIL rx_glitch: got %h expected 00000028", d); end
  endtask

  task automatic test_rx_err;
    logic [1:0] r; logic [31:0] d;
    send_rx(8'h5A, 1'b0); tick(4);
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h8000_0028) begin n_fail++; $display("FAIL rx_frame_err: got %h expected 80000028", d); end
    axi_write(REG_CONF, 32'h8000_0000, r);
    n_tests++; if (r !== RESP_OKAY) begin n_fail++; $display("FAIL rx_err_clear_resp: got %b expected 00", r); end
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h0000_0028) begin n_fail++; $display("FAIL rx_err_cleared: got %h expected 00000028", d); end
  endtask

  task automatic test_rx_overflow;
    logic [1:0] r; logic [31:0] d;
    for (int k = 1; k <= 5; k++) begin send_rx(8'(k), 1'b1); tick(2); end
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h8000_0024) begin n_fail++; $display("FAIL ovf_conf: got %h expected 80000024", d); end
    for (int k = 1; k <= 4; k++) begin
      axi_read(REG_DATA, d, r);
      n_tests++; if ({r, d} !== {RESP_OKAY, 32'(k)}) begin
        n_fail++; $display("FAIL ovf_read%0d: got %b/%h expected 00/%h", k, r, d, 32'(k)); end
    end
    axi_read(REG_DATA, d, r);
    n_tests++; if ({r, d} !== {RESP_SLVERR, 32'h0}) begin
      n_fail++; $display("FAIL ovf_read_empty: got %b/%h expected 10/00000000", r, d); end
    axi_write(REG_CONF, 32'h8000_0000, r);
  endtask

  task automatic test_irq;
    logic [1:0] r; logic [31:0] d;
    axi_write(REG_CONF, 32'h3, r); tick(3);
    n_tests++; if ({rx_int, tx_int} !== 2'b01) begin n_fail++; $display("FAIL irq_enabled_idle: got %b expected 01", {rx_int, tx_int}); end
    send_rx(8'h77, 1'b1); tick(4);
    n_tests++; if (rx_int !== 1'b1) begin n_fail++; $display("FAIL irq_rx_set: got %b expected 1", rx_int); end
    axi_read(REG_DATA, d, r); tick(3);
    n_tests++; if ({d[7:0], rx_int} !== {8'h77, 1'b0}) begin
      n_fail++; $display("FAIL irq_rx_clear: got %h/%b expected 77/0", d[7:0], rx_int); end
    axi_write(REG_CONF, 32'h0, r); tick(3);
    n_tests++; if (tx_int !== 1'b0) begin n_fail++; $display("FAIL irq_tx_disable: got %b expected 0", tx_int); end
  endtask

  task automatic test_bad_addr;
    logic [1:0] r; logic [31:0] d;
    axi_write(3'h2, 32'h3, r);
    n_tests++; if (r !== RESP_SLVERR) begin n_fail++; $display("FAIL bad_wr_resp: got %b expected 10", r); end
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h0000_0028) begin n_fail++; $display("FAIL bad_wr_no_effect: got %h expected 00000028", d); end
    axi_read(3'h6, d, r);
    n_tests++; if ({r, d} !== {RESP_SLVERR, 32'h0}) begin
      n_fail++; $display("FAIL bad_rd: got %b/%h expected 10/00000000", r, d); end
  endtask

  task automatic test_reset_midframe;
    logic [1:0] r; logic [31:0] d; int highs = 0;
    axi_write(REG_DATA, 32'h00, r);
    axi_write(REG_DATA, 32'h00, r);
    tick(20);
    n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_tx_low: got %b expected 0", tx); end
    rst = 1'b1; tick(1);
    n_tests++; if ({tx, arready, awready, bvalid, rvalid} !== 5'b10000) begin
      n_fail++; $display("FAIL midframe_reset: got %b expected 10000", {tx, arready, awready, bvalid, rvalid}); end
    tick(1); rst = 1'b0; tick(1);
    axi_read(REG_CONF, d, r);
    n_tests++; if (d !== 32'h0000_0028) begin n_fail++; $display("FAIL midframe_conf: got %h expected 00000028", d); end
    record_tx(100);
    for (int i = 0; i < 100; i++) if (tx_log[i] === 1'b1) highs++;
    n_tests++; if (highs != 100) begin n_fail++; $display("FAIL midframe_tx_idle: got %0d high samples expected 100", highs); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_glitch();
    test_rx_err();
    test_rx_overflow();
    test_irq();
    test_bad_addr();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
